// File: rtl/pwm_bank_fade.sv
// Multi-channel PWM bank for the LED pins: a shared prescaled counter with per-channel
// target/current duty. Duty changes land only at period wraps, optionally ramped by one LSB per period.
module pwm_bank_fade #(
    parameter int CH  = 6,
    parameter int CW  = 8,
    parameter int DIV = 1,
    localparam int WCW = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           en,
    input  logic           wr,
    input  logic [WCW-1:0] wr_ch,
    input  logic [CW-1:0]  wr_duty,
    input  logic           wr_fade,
    input  logic [CH-1:0]  LED_in,
    output logic [CH-1:0]  LED_o,
    output logic           period_start,
    output logic           busy
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = {CW{1'b1}};

    logic [PW-1:0] pre;
    logic [CW-1:0] cnt;
    logic [CW-1:0] tgt [CH];
    logic [CW-1:0] cur [CH];
    logic [CW-1:0] tgt_next [CH];
    logic [CW-1:0] cur_next [CH];
    logic [CH-1:0] fade;
    logic [CH-1:0] fade_next;
    logic          wrap_d;
    logic          tick;
    logic          wrap;
    logic          wr_ok;
    logic          busy_next;

    assign tick  = en && (pre == PRE_LAST);
    assign wrap  = tick && (cnt == CNT_LAST);
    assign wr_ok = wr && (int'(wr_ch) < CH);

    // The wrap step reads the old target, so a write in the wrap cycle only counts at the next wrap.
    always_comb begin
        busy_next = 1'b0;
        fade_next = fade;
        for (int i = 0; i < CH; i++) begin
            tgt_next[i] = tgt[i];
            cur_next[i] = cur[i];
            if (wrap) begin
                if (!fade[i]) begin
                    cur_next[i] = tgt[i];
                end else if (cur[i] < tgt[i]) begin
                    cur_next[i] = cur[i] + 1'b1;
                end else if (cur[i] > tgt[i]) begin
                    cur_next[i] = cur[i] - 1'b1;
                end
            end
            if (wr_ok && (int'(wr_ch) == i)) begin
                tgt_next[i]  = wr_duty;
                fade_next[i] = wr_fade;
            end
            busy_next = busy_next | (cur_next[i] != tgt_next[i]);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pre          <= '0;
            cnt          <= '0;
            LED_o        <= '0;
            period_start <= 1'b0;
            wrap_d       <= 1'b0;
            busy         <= 1'b0;
            fade         <= '0;
            for (int i = 0; i < CH; i++) begin
                tgt[i] <= '0;
                cur[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                tgt[i] <= tgt_next[i];
                cur[i] <= cur_next[i];
            end
            fade <= fade_next;
            busy <= busy_next;
            if (!en) begin
                pre          <= '0;
                cnt          <= '0;
                LED_o        <= '0;
                period_start <= 1'b0;
                wrap_d       <= 1'b0;
            end else begin
                pre <= tick ? '0 : pre + 1'b1;
                if (tick) begin
                    cnt <= cnt + 1'b1;
                end
                // Delayed one extra cycle so the pulse lines up with the first pin sample of the new period.
                wrap_d       <= wrap;
                period_start <= wrap_d;
                for (int i = 0; i < CH; i++) begin
                    LED_o[i] <= LED_in[i] & (cnt < cur[i]);
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_bank_fade.sv
// Directed bench for pwm_bank_fade: a CW=8/DIV=1 bank for duty, fade, enable and reset behaviour,
// plus a CW=4/DIV=3 bank for prescaling and the write-at-wrap collision.
module tb_pwm_bank_fade;

    logic       CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       rst_a, en_a, wr_a, wr_fade_a;
    logic [2:0] wr_ch_a;
    logic [7:0] wr_duty_a;
    logic [5:0] led_in_a, led_a;
    logic       ps_a, busy_a;

    logic       rst_b, en_b, wr_b, wr_fade_b;
    logic [0:0] wr_ch_b;
    logic [3:0] wr_duty_b;
    logic [1:0] led_in_b, led_b;
    logic       ps_b, busy_b;

    int checks = 0;
    int failures = 0;

    pwm_bank_fade #(.CH(6), .CW(8), .DIV(1)) dut_a (
        .CLK(CLK), .RST(rst_a), .en(en_a), .wr(wr_a), .wr_ch(wr_ch_a),
        .wr_duty(wr_duty_a), .wr_fade(wr_fade_a), .LED_in(led_in_a),
        .LED_o(led_a), .period_start(ps_a), .busy(busy_a)
    );

    pwm_bank_fade #(.CH(2), .CW(4), .DIV(3)) dut_b (
        .CLK(CLK), .RST(rst_b), .en(en_b), .wr(wr_b), .wr_ch(wr_ch_b),
        .wr_duty(wr_duty_b), .wr_fade(wr_fade_b), .LED_in(led_in_b),
        .LED_o(led_b), .period_start(ps_b), .busy(busy_b)
    );

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // One-cycle write into bank A, driven from a negedge.
    task automatic applyStimulus(input int ch, input int duty, input bit fade);
        wr_a      = 1'b1;
        wr_ch_a   = 3'(ch);
        wr_duty_a = 8'(duty);
        wr_fade_a = fade;
        @(negedge CLK);
        wr_a = 1'b0;
    endtask

    // Waits for period_start, then counts high samples of one channel over exactly one period.
    task automatic measurePeriod(input bit use_b, input int ch, output int high, output int others);
        int         len;
        int         guard;
        logic [5:0] leds;
        len    = use_b ? 48 : 256;
        high   = 0;
        others = 0;
        guard  = 0;
        while (!(use_b ? ps_b : ps_a) && guard < 2 * len + 8) begin
            @(negedge CLK);
            guard++;
        end
        if (guard >= 2 * len + 8) begin
            checkOutput("period_start_timeout", 0, 1);
            return;
        end
        for (int i = 0; i < len; i++) begin
            leds = use_b ? {4'b0, led_b} : led_a;
            if (leds[ch]) high++;
            if ((leds & ~(6'b1 << ch)) != 6'b0) others++;
            @(negedge CLK);
        end
    endtask

    initial begin
        int high, others, hits, busy_hits, pulses, first, second, guard;

        rst_a = 1'b1; en_a = 1'b0; wr_a = 1'b0; wr_ch_a = '0; wr_duty_a = '0;
        wr_fade_a = 1'b0; led_in_a = '0;
        rst_b = 1'b1; en_b = 1'b0; wr_b = 1'b0; wr_ch_b = '0; wr_duty_b = '0;
        wr_fade_b = 1'b0; led_in_b = '0;
        repeat (2) @(negedge CLK);
        rst_a = 1'b0;
        rst_b = 1'b0;

        checkOutput("reset_led_a", int'(led_a), 0);
        checkOutput("reset_busy_a", int'(busy_a), 0);
        checkOutput("reset_ps_a", int'(ps_a), 0);
        checkOutput("reset_led_b", int'(led_b), 0);

        // Default duties of 0: pins stay low, period_start every 256 cycles.
        en_a = 1'b1;
        led_in_a = 6'h3F;
        hits = 0; busy_hits = 0; pulses = 0; first = 0; second = 0;
        for (int i = 1; i <= 600; i++) begin
            @(negedge CLK);
            if (led_a != 6'b0) hits++;
            if (busy_a) busy_hits++;
            if (ps_a) begin
                pulses++;
                if (first == 0) first = i;
                else if (second == 0) second = i;
            end
        end
        checkOutput("default_led_low", hits, 0);
        checkOutput("default_busy_low", busy_hits, 0);
        checkOutput("default_pulse_count", pulses, 2);
        checkOutput("default_pulse_spacing", second - first, 256);

        // Jump update lands only at the next wrap.
        applyStimulus(2, 64, 1'b0);
        checkOutput("jump_busy_set", int'(busy_a), 1);
        hits = 0; guard = 0;
        while (!ps_a && guard < 600) begin
            if (led_a[2]) hits++;
            @(negedge CLK);
            guard++;
        end
        checkOutput("jump_no_midperiod_glitch", hits, 0);
        measurePeriod(1'b0, 2, high, others);
        checkOutput("jump_ch2_high", high, 64);
        checkOutput("jump_others_low", others, 0);
        checkOutput("jump_busy_clear", int'(busy_a), 0);

        // Fade up 1..10, then down 9..7.
        applyStimulus(0, 10, 1'b1);
        checkOutput("fade_up_busy_set", int'(busy_a), 1);
        for (int k = 1; k <= 10; k++) begin
            measurePeriod(1'b0, 0, high, others);
            checkOutput($sformatf("fade_up_p%0d", k), high, k);
            checkOutput($sformatf("fade_up_busy_p%0d", k), int'(busy_a), int'(k < 9));
        end
        applyStimulus(0, 7, 1'b1);
        checkOutput("fade_down_busy_set", int'(busy_a), 1);
        for (int k = 1; k <= 3; k++) begin
            measurePeriod(1'b0, 0, high, others);
            checkOutput($sformatf("fade_down_p%0d", k), high, 10 - k);
            checkOutput($sformatf("fade_down_busy_p%0d", k), int'(busy_a), int'(k < 2));
        end

        // Duty boundaries and the per-channel gate.
        applyStimulus(1, 255, 1'b0);
        measurePeriod(1'b0, 1, high, others);
        checkOutput("ch1_duty_max", high, 255);
        applyStimulus(1, 0, 1'b0);
        measurePeriod(1'b0, 1, high, others);
        checkOutput("ch1_duty_zero", high, 0);
        led_in_a = 6'h3D;
        applyStimulus(1, 255, 1'b0);
        measurePeriod(1'b0, 1, high, others);
        checkOutput("ch1_gated_off", high, 0);
        led_in_a = 6'h3F;

        // Enable low for 20 cycles with a target write; current duty must stay frozen.
        repeat (40) @(negedge CLK);
        en_a = 1'b0;
        wr_a = 1'b1; wr_ch_a = 3'd2; wr_duty_a = 8'd100; wr_fade_a = 1'b0;
        hits = 0; pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            wr_a = 1'b0;
            if (led_a != 6'b0) hits++;
            if (ps_a) pulses++;
        end
        checkOutput("disabled_led_low", hits, 0);
        checkOutput("disabled_no_pulse", pulses, 0);
        checkOutput("disabled_busy_pending", int'(busy_a), 1);
        en_a = 1'b1;
        hits = 0; pulses = 0;
        for (int i = 1; i <= 255; i++) begin
            @(negedge CLK);
            if (led_a[2]) hits++;
            if (ps_a) pulses++;
        end
        checkOutput("restart_cur_frozen", hits, 64);
        checkOutput("restart_no_pulse", pulses, 0);
        measurePeriod(1'b0, 2, high, others);
        checkOutput("restart_new_duty", high, 100);

        // Reset in the middle of a fade.
        applyStimulus(0, 200, 1'b1);
        measurePeriod(1'b0, 0, high, others);
        checkOutput("fade_before_reset", high, 8);
        repeat (30) @(negedge CLK);
        rst_a = 1'b1;
        @(negedge CLK);
        checkOutput("midreset_led", int'(led_a), 0);
        checkOutput("midreset_busy", int'(busy_a), 0);
        checkOutput("midreset_ps", int'(ps_a), 0);
        rst_a = 1'b0;
        measurePeriod(1'b0, 0, high, others);
        checkOutput("after_reset_ch0", high, 0);
        checkOutput("after_reset_others", others, 0);
        checkOutput("after_reset_busy", int'(busy_a), 0);

        // Bank B: 16 ticks of 3 cycles each.
        en_b = 1'b1;
        led_in_b = 2'b11;
        first = 0; second = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge CLK);
            if (ps_b) begin
                if (first == 0) first = i;
                else if (second == 0) second = i;
            end
        end
        checkOutput("prescale_pulse_spacing", second - first, 48);

        // Write presented in the wrap cycle itself: old target holds for one more period.
        guard = 0;
        while (!ps_b && guard < 100) begin
            @(negedge CLK);
            guard++;
        end
        checkOutput("prescale_found_pulse", int'(ps_b), 1);
        repeat (46) @(negedge CLK);
        wr_b = 1'b1; wr_ch_b = 1'b0; wr_duty_b = 4'd8; wr_fade_b = 1'b0;
        @(negedge CLK);
        wr_b = 1'b0;
        measurePeriod(1'b1, 0, high, others);
        checkOutput("collision_old_duty", high, 0);
        measurePeriod(1'b1, 0, high, others);
        checkOutput("collision_new_duty", high, 24);
        checkOutput("collision_busy_clear", int'(busy_b), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
